// File: rtl/aes_key_mem.sv
// AES round-key expansion and storage for AES-128/AES-256. The engine produces
// one round key per cycle into a register array that is read combinationally.

module aes_sbox (
  input  logic [7:0] addr,
  output logic [7:0] data
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign data = SBOX[addr];

endmodule

module aes_key_mem #(
  parameter logic [3:0] AES_128_ROUNDS = 4'd10,
  parameter logic [3:0] AES_256_ROUNDS = 4'd14
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic [255:0] key,
  input  logic [1:0]   keylen,
  input  logic [3:0]   round_key_addr,
  output logic [127:0] round_key,
  output logic         ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GEN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]   state;
  logic [3:0]   round_ctr;
  logic [7:0]   rcon;
  logic [255:0] key_reg;
  logic         is_256;
  logic [127:0] mem [0:14];
  logic [127:0] prev_key;
  logic [127:0] prev2_key;

  logic         init_ok;
  logic [3:0]   last_idx;
  logic         use_rot;
  logic         use_rcon;
  logic [31:0]  sbox_in;
  logic [31:0]  sub_word;
  logic [31:0]  t;
  logic [127:0] base;
  logic [31:0]  w0, w1, w2, w3;
  logic [127:0] new_key;

  // Reserved keylen codes (2'h1, 2'h3) make init a no-op.
  assign init_ok  = init && (keylen == 2'h0 || keylen == 2'h2);
  assign last_idx = is_256 ? AES_256_ROUNDS : AES_128_ROUNDS;

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .addr (sbox_in[8*i +: 8]),
      .data (sub_word[8*i +: 8])
    );
  end

  // AES-256 odd steps use a plain SubWord; every rotating step also consumes rcon.
  always_comb begin
    use_rot  = !is_256 || !round_ctr[0];
    use_rcon = is_256 ? (round_ctr >= 4'd2 && !round_ctr[0]) : (round_ctr != 4'd0);
    sbox_in  = use_rot ? {prev_key[23:0], prev_key[31:24]} : prev_key[31:0];
    t        = sub_word ^ (use_rot ? {rcon, 24'h0} : 32'h0);
    base     = is_256 ? prev2_key : prev_key;
    w0       = base[127:96] ^ t;
    w1       = base[95:64]  ^ w0;
    w2       = base[63:32]  ^ w1;
    w3       = base[31:0]   ^ w2;
    if (round_ctr == 4'd0)
      new_key = key_reg[255:128];
    else if (is_256 && round_ctr == 4'd1)
      new_key = key_reg[127:0];
    else
      new_key = {w0, w1, w2, w3};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      round_ctr <= 4'd0;
      rcon      <= 8'h01;
      key_reg   <= '0;
      is_256    <= 1'b0;
      ready     <= 1'b0;
      prev_key  <= '0;
      prev2_key <= '0;
      // NOTE: the key array is reset explicitly so unread/aborted slots read as zero;
      // this forces it into flops rather than a RAM macro, which is intended here.
      for (int i = 0; i < 15; i++) mem[i] <= '0;
    end else if (init_ok) begin
      state     <= ST_GEN;
      round_ctr <= 4'd0;
      rcon      <= 8'h01;
      key_reg   <= key;
      is_256    <= keylen[1];
      ready     <= 1'b0;
    end else if (state == ST_GEN) begin
      mem[round_ctr] <= new_key;
      prev_key       <= new_key;
      prev2_key      <= prev_key;
      if (use_rcon)
        rcon <= {rcon[6:0], 1'b0} ^ (8'h1b & {8{rcon[7]}});
      if (round_ctr == last_idx) begin
        state <= ST_DONE;
        ready <= 1'b1;
      end else begin
        round_ctr <= round_ctr + 4'd1;
      end
    end
  end

  always_comb begin
    round_key = '0;
    if (round_key_addr <= last_idx)
      round_key = mem[round_key_addr];
  end

endmodule

// File: doc/aes_key_mem.md
Name: aes_key_mem

Overview:
Round-key generator and store directly upstream of the AES decipher round. On init it expands a 128- or 256-bit cipher key into 11 or 15 round keys, one round key per cycle, and holds them in an internal register array. The decipher control then reads any key combinationally by index through the round_key_addr/round_key pair. Four byte S-box instances (aes_sbox, 8-bit addr/data) provide SubWord.

Parameters:
AES_128_ROUNDS, 10, last round-key index for keylen 2'h0.
AES_256_ROUNDS, 14, last round-key index for keylen 2'h2.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset_n  input  1  asynchronous active-low reset.
init  input  1  single-cycle pulse that starts key expansion.
key  input  256  cipher key. AES-128 uses key[255:128]; AES-256 uses all 256 bits.
keylen  input  2  2'h0 = AES-128, 2'h2 = AES-256; 2'h1/2'h3 are reserved.
round_key_addr  input  4  index of the round key to read.
round_key  output  128  combinational read of the selected round key.
ready  output  1  all round keys for the latched keylen are valid.

Behaviour:
- Reset:
  - ready = 0.
  - All 15 key registers = 128'h0.
  - FSM in IDLE; round counter = 0; rcon = 8'h01.
  - round_key therefore reads 128'h0.
- FSM states:
  - IDLE -> GEN on init with a legal keylen; key and keylen are latched and ready is cleared on that edge (edge N).
  - GEN: one round key is written per cycle; address k is written on edge N+1+k.
  - GEN -> DONE on the edge that writes the last index (10 or 14). ready is set on that same edge, so ready = 1 from edge N+11 (AES-128) or N+15 (AES-256).
  - DONE -> GEN on a new init, restarting from address 0.
- init with a reserved keylen is ignored: no state change, ready unchanged.
- init while in GEN aborts the current expansion and restarts from address 0 with the new key. ready stays 0 throughout.
- Expansion, with w[] denoting 32-bit words and prev = the key written in the previous cycle:
  - AES-128: addr 0 = key[255:128]. addr k (k ≥ 1): t = SubWord(RotWord(prev.w3)) ^ {rcon, 24'h0}; then w0 = prev.w0^t, w1 = prev.w1^w0, w2 = prev.w2^w1, w3 = prev.w3^w2.
  - AES-256: addr 0 = key[255:128], addr 1 = key[127:0]. For k ≥ 2, base = key k-2 and t is derived from key k-1's w3:
    - even k: t = SubWord(RotWord(w3)) ^ rcon.
    - odd k: t = SubWord(w3), with no rotate and no rcon.
    - Then the same XOR chain as AES-128, applied to base.
  - RotWord is a left rotate by 8 bits. SubWord uses four aes_sbox instances, one per byte.
- rcon:
  - Reset to 8'h01 on init.
  - After each use it advances by xtime: {rcon[6:0],1'b0} ^ (8'h1b & {8{rcon[7]}}).
  - It advances only on rcon-using cycles, giving 01,02,04,08,10,20,40,80,1b,36.
- Read side:
  - round_key = mem[round_key_addr] when round_key_addr ≤ the last index for the latched keylen; otherwise 128'h0.
  - Reads during GEN return current register contents and carry no validity guarantee.
- Latched keylen and key do not change between inits; changes on the key port after init have no effect.
- A reset_n assertion at any time (including mid-GEN) forces the reset state asynchronously.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, init pulse -> ready rises exactly 11 cycles after init. Reads: addr 0 = 2b7e1516...4f3c; addr 1 = a0fafe1788542cb123a339392a6c7605; addr 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; addr 11 = 0.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> ready after 15 cycles. Reads: addr 2 = 9ba354118e6925afa51a8b5f2067fcde; addr 14 = fe4890d1e6188d0b046df344706c631e.
- AES-128 vector, then a second init at cycle 5 of generation with the AES-256 key -> ready stays 0, then rises 15 cycles after the second init. Final keys match the AES-256 vector.
- init with keylen 2'h1 after a completed AES-128 expansion -> ready stays 1 and addr 10 is still d014f9a8c9ee2589e13f0cc8b6630ca6.
- Assert reset_n low mid-generation (cycle 6) -> ready = 0 and every address reads 0 immediately. A fresh init then reproduces the FIPS-197 keys.
- Back-to-back AES-128 expansions with the same key -> identical key set both times, confirming rcon restarts at 01 on each init.
